inference_sequencer: RTL and testbench
======================================

# inference_sequencer

Top-level controller that runs one inference through the layer chain: conv layers, fc1, fc2. It launches each layer in order using the layers' start/done handshake, then scans the fc2 score vector serially to find the winning class. It sits above the layer instances and is the only driver of their `start` inputs.

## Interface
- `NUM_LAYERS`, default 4: number of sequenced layers; index 0 runs first, index `NUM_LAYERS-1` is fc2.
- `NUM_CLASSES`, default 10: number of fc2 scores scanned by argmax.
- `TIMEOUT_CYCLES`, default 65535: per-layer watchdog limit. Used only with `SEQ_TIMEOUT_EN`.

- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: level request to start one inference. Sampled only in IDLE.
- `busy`, out, 1: high while a run is in progress.
- `done`, out, 1: run complete. Held high until `run` is low.
- `err`, out, 1: a layer timed out during this run.
- `layer_start`, out, `NUM_LAYERS`: one-hot start line to each layer. Registered.
- `layer_done`, in, `NUM_LAYERS`: done line from each layer. Sticky until that layer is restarted.
- `scores`, in, signed 32 x `NUM_CLASSES`: fc2 outputs. Stable while fc2 is idle.
- `class_id`, out, `$clog2(NUM_CLASSES)`: index of the maximum score.
- `class_score`, out, signed 32: the maximum score value.

## Operation
- Reset value of every output is 0. Reset drives all `layer_start` bits to 0 immediately.
- State machine:
  - IDLE: when `run` = 1, clear `class_id`, `class_score` and `err`, set layer index k = 0, go to LAUNCH.
  - LAUNCH: `layer_start[k]` goes high; set guard counter = 0; go to WAIT_DONE.
  - WAIT_DONE: hold `layer_start[k]` high. `layer_done[k]` is ignored until the guard counter reaches 2, because a stale sticky done from the previous run needs one cycle to clear. After that, `layer_done[k]` = 1 moves to RELEASE.
  - RELEASE: `layer_start[k]` goes low. If k = `NUM_LAYERS-1`, go to ARGMAX; otherwise k++ and go to LAUNCH.
  - ARGMAX: uses index i = 0..`NUM_CLASSES-1`, one score per cycle.
    - At i = 0: load `class_id` = 0 and `class_score` = `scores[0]`.
    - For i > 0: update only if `scores[i]` > `class_score` (signed, strict compare). Ties keep the lowest index.
    - After i = `NUM_CLASSES-1`, go to FINISH.
  - FINISH: `done` = 1, `busy` = 0. When `run` = 0, go to IDLE and `done` returns to 0.
- `busy` is high in LAUNCH, WAIT_DONE, RELEASE and ARGMAX.
- At most one `layer_start` bit is high at any time.
- `run` falling mid-run is ignored; the sequence completes.
- `run` still high after FINISH does not start a second run; the controller waits for `run` low.
- Asynchronous reset mid-run abandons the run. Layers see their start go low and return to idle through their own WAIT_START_LOW state.

## Timing
- Define D_k = cycles from `layer_start[k]` high to `layer_done[k]` high, with D_k ≥ 2 enforced by the guard.
- `run` is sampled at edge e0. `layer_start[0]` is high from e0+1.
- Each layer costs D_k + 2 cycles (LAUNCH plus RELEASE).
- `done` rises at e0 + 1 + Σ(D_k + 2) + `NUM_CLASSES`.
- `class_id` and `class_score` are final when `done` rises. They hold until the next run is accepted.
- RELEASE guarantees `layer_start[k]` is low for at least 1 cycle before any later reassertion.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT_DONE.
  - On reaching `TIMEOUT_CYCLES`: drop `layer_start[k]`, set `err` = 1, skip the remaining layers and ARGMAX.
  - Go to FINISH with `class_id` = 0 and `class_score` = 0.
- Not defined:
  - No counter is instantiated and `err` is tied to 0.
  - WAIT_DONE waits indefinitely.

## Structure
- Shared package `quickdraw_pkg`:
  - `seq_state_t` enum: IDLE, LAUNCH, WAIT_DONE, RELEASE, ARGMAX, FINISH.
  - `NUM_CLASSES` constant.
  - `score_t` typedef (signed 32).
- Sub-module `argmax_serial`:
  - Inputs: `clk`, `reset_n`, `first`, `valid`, `idx`, `score`.
  - Outputs: `class_id`, `class_score`.
  - The sequencer drives it during ARGMAX.

## Test plan
- Basic run: stub layers with D = 5, `NUM_LAYERS` = 4, `scores` = {0,1,2,3,4,5,6,99,8,9}, `run` = 1.
  - Required: `done` at e0 + 39, `class_id` = 7, `class_score` = 99, `err` = 0.
- Tie: scores 50 at indices 2 and 5, all others 10.
  - Required: `class_id` = 2.
- All-negative scores: -100 everywhere except -3 at index 4.
  - Required: `class_id` = 4, `class_score` = -3.
- Stale done: all `layer_done` held high at run start, clearing 1 cycle after each start.
  - Required: no layer advances before guard = 2; the launch order is 0,1,2,3 with one-hot `layer_start`.
- Timeout (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 20): layer 2 never asserts done.
  - Required: `err` = 1 and `done` = 1 after 20 WAIT_DONE cycles; `layer_start` = 0; `class_id` = 0.
- Reset mid-run: `reset_n` low during WAIT_DONE of layer 1.
  - Required: all outputs 0 immediately.
  - Required: a following `run` completes normally with correct `class_id`.

Source files
------------

// File: rtl/quickdraw_pkg.sv
// Shared types and constants for the quickdraw inference pipeline.
package quickdraw_pkg;

   localparam int unsigned NUM_CLASSES = 10;
   // Cycles a layer's done is ignored after launch so a stale sticky done can clear.
   localparam int unsigned GuardCycles = 2;

   typedef logic signed [31:0] score_t;

   typedef enum logic [2:0] {
      StIdle,
      StLaunch,
      StWaitDone,
      StRelease,
      StArgmax,
      StFinish
   } seq_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/inference_sequencer_if.sv
// Control/result bundle between the inference sequencer, its host and the layer chain.
interface inference_sequencer_if #(
   parameter int unsigned NUM_LAYERS  = 4,
   parameter int unsigned NUM_CLASSES = quickdraw_pkg::NUM_CLASSES
);
   import quickdraw_pkg::*;

   localparam int unsigned IdxW = idx_width(NUM_CLASSES);

   logic                  run;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [NUM_LAYERS-1:0] layer_start;
   logic [NUM_LAYERS-1:0] layer_done;
   score_t                scores [NUM_CLASSES];
   logic [IdxW-1:0]       class_id;
   score_t                class_score;

   modport master (
      input  run, layer_done, scores,
      output busy, done, err, layer_start, class_id, class_score
   );

   modport slave (
      output run, layer_done, scores,
      input  busy, done, err, layer_start, class_id, class_score
   );

endinterface

// File: rtl/argmax_serial.sv
// Serial running argmax: one score per valid cycle, strict signed compare so ties keep the
// lowest index; 'first' reloads the running best unconditionally.
module argmax_serial #(
   parameter int unsigned NUM_CLASSES = quickdraw_pkg::NUM_CLASSES,
   localparam int unsigned IdxW = quickdraw_pkg::idx_width(NUM_CLASSES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  first,
   input  logic                  valid,
   input  logic [IdxW-1:0]       idx,
   input  quickdraw_pkg::score_t score,
   output logic [IdxW-1:0]       class_id,
   output quickdraw_pkg::score_t class_score
);
   import quickdraw_pkg::*;

   logic [IdxW-1:0] class_id_q, class_id_d;
   score_t          class_score_q, class_score_d;

   always_comb begin
      class_id_d    = class_id_q;
      class_score_d = class_score_q;
      if (valid && (first || (score > class_score_q))) begin
         class_id_d    = idx;
         class_score_d = score;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         class_id_q    <= '0;
         class_score_q <= '0;
      end else begin
         class_id_q    <= class_id_d;
         class_score_q <= class_score_d;
      end
   end

   assign class_id    = class_id_q;
   assign class_score = class_score_q;

endmodule

// File: rtl/inference_sequencer.sv
// Launches each layer in order via start/done, then serially argmaxes the fc2 scores.
// Optional per-layer watchdog enabled by defining SEQ_TIMEOUT_EN.
module inference_sequencer #(
   parameter int unsigned NUM_LAYERS     = 4,
   parameter int unsigned NUM_CLASSES    = quickdraw_pkg::NUM_CLASSES,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input logic                   clk,
   input logic                   reset_n,
   inference_sequencer_if.master bus
);
   import quickdraw_pkg::*;

   localparam int unsigned IdxW   = idx_width(NUM_CLASSES);
   localparam int unsigned LayerW = idx_width(NUM_LAYERS);
   localparam logic [LayerW-1:0] LastLayer = LayerW'(NUM_LAYERS - 1);
   localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NUM_CLASSES - 1);
   localparam logic [1:0]        GuardMax  = 2'(GuardCycles);

   seq_state_t            state_q, state_d;
   logic [LayerW-1:0]     layer_q, layer_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [1:0]            guard_q, guard_d;
   logic [NUM_LAYERS-1:0] start_q, start_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic            am_first, am_valid;
   logic [IdxW-1:0] am_idx;
   score_t          am_score;
   logic            guard_ok, done_seen, timeout;

   // Guard reaches GuardCycles on this edge, so layer_done may be trusted now.
   assign guard_ok  = (guard_q + 2'd1) >= GuardMax;
   assign done_seen = guard_ok && bus.layer_done[layer_q];

`ifdef SEQ_TIMEOUT_EN
   logic [15:0] wd_q, wd_d;
   logic        err_q, err_d;

   assign timeout = (state_q == StWaitDone) && !done_seen &&
                    (wd_q == 16'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wd_d  = '0;
      err_d = err_q;
      if (state_q == StWaitDone) wd_d = wd_q + 16'd1;
      if (state_q == StIdle && bus.run) err_d = 1'b0;
      if (timeout) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign timeout = 1'b0;
   assign bus.err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      idx_d    = idx_q;
      guard_d  = guard_q;
      am_first = 1'b0;
      am_valid = 1'b0;
      am_idx   = idx_q;
      am_score = bus.scores[idx_q];

      unique case (state_q)
         StIdle: begin
            if (bus.run) begin
               // Clearing the result is a forced load of score 0 at index 0.
               am_first = 1'b1;
               am_valid = 1'b1;
               am_idx   = '0;
               am_score = '0;
               layer_d  = '0;
               state_d  = StLaunch;
            end
         end
         StLaunch: begin
            guard_d = '0;
            state_d = StWaitDone;
         end
         StWaitDone: begin
            if (guard_q != GuardMax) guard_d = guard_q + 2'd1;
            if (done_seen) begin
               state_d = StRelease;
            end else if (timeout) begin
               am_first = 1'b1;
               am_valid = 1'b1;
               am_idx   = '0;
               am_score = '0;
               state_d  = StFinish;
            end
         end
         StRelease: begin
            if (layer_q == LastLayer) begin
               idx_d   = '0;
               state_d = StArgmax;
            end else begin
               layer_d = layer_q + 1'b1;
               state_d = StLaunch;
            end
         end
         StArgmax: begin
            am_valid = 1'b1;
            am_first = (idx_q == '0);
            if (idx_q == LastIdx) state_d = StFinish;
            else idx_d = idx_q + 1'b1;
         end
         StFinish: begin
            if (!bus.run) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d  = state_d inside {StLaunch, StWaitDone, StRelease, StArgmax};
      done_d  = (state_d == StFinish);
      start_d = '0;
      if (state_d == StLaunch || state_d == StWaitDone) start_d[layer_d] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         layer_q <= '0;
         idx_q   <= '0;
         guard_q <= '0;
         start_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         idx_q   <= idx_d;
         guard_q <= guard_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   logic [IdxW-1:0] class_id;
   score_t          class_score;

   argmax_serial #(
      .NUM_CLASSES (NUM_CLASSES)
   ) u_argmax (
      .clk         (clk),
      .reset_n     (reset_n),
      .first       (am_first),
      .valid       (am_valid),
      .idx         (am_idx),
      .score       (am_score),
      .class_id    (class_id),
      .class_score (class_score)
   );

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.layer_start = start_q;
   assign bus.class_id    = class_id;
   assign bus.class_score = class_score;

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: stub layers with programmable latency, a vector table of
// score patterns and a scoreboard of expected results popped when done rises.
module tb_inference_sequencer;
   import quickdraw_pkg::*;

   localparam int NL     = 4;
   localparam int NC     = 10;
   localparam int TO     = 20;
   localparam int Budget = 300;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   inference_sequencer_if #(.NUM_LAYERS(NL), .NUM_CLASSES(NC)) bus ();

   inference_sequencer #(
      .NUM_LAYERS     (NL),
      .NUM_CLASSES    (NC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Stub layers: done set after dly cycles of start, cleared at start count clr_at.
   logic [NL-1:0] ldone = '0;
   logic [NL-1:0] hang  = '0;
   int            lcnt [NL];
   int            dly    = 5;
   int            clr_at = 1;
   logic          preset = 1'b0;
   assign bus.layer_done = ldone;

   always @(posedge clk) begin
      for (int l = 0; l < NL; l++) begin
         if (preset) begin
            ldone[l] <= 1'b1;
            lcnt[l]  <= 0;
         end else if (bus.layer_start[l]) begin
            lcnt[l] <= lcnt[l] + 1;
            if (!hang[l] && lcnt[l] + 1 == dly) ldone[l] <= 1'b1;
            else if (lcnt[l] + 1 == clr_at) ldone[l] <= 1'b0;
         end else begin
            lcnt[l] <= 0;
         end
      end
   end

   int            onehot_bad = 0;
   int            order_q [$];
   logic [NL-1:0] start_prev = '0;
   always @(negedge clk) begin
      if ($countones(bus.layer_start) > 1) onehot_bad <= onehot_bad + 1;
      for (int l = 0; l < NL; l++)
         if (bus.layer_start[l] && !start_prev[l]) order_q.push_back(l);
      start_prev <= bus.layer_start;
   end

   typedef struct {
      score_t     sc [NC];
      logic [3:0] id;
      score_t     best;
      bit         drop_run;
   } vec_t;

   typedef struct {
      logic [3:0] id;
      score_t     best;
      logic       err;
      int         lat;
      int         nl;
   } exp_t;

   vec_t vecs [6];
   exp_t sb_q [$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int run_lat(input int d);
      return 1 + NL * (d + 2) + NC;
   endfunction

   // Run latency t counts negedge samples; t=1 is the cycle after the edge that samples run.
   task automatic run_once(input vec_t v, input logic [3:0] id_exp, input score_t best_exp,
                           input logic err_exp, input int lat_exp, input int nl_exp,
                           input string tag);
      int   t;
      int   base;
      exp_t e;
      base = order_q.size();
      @(negedge clk);
      bus.scores = v.sc;
      sb_q.push_back('{id: id_exp, best: best_exp, err: err_exp, lat: lat_exp, nl: nl_exp});
      bus.run = 1'b1;
      @(negedge clk);
      t = 1;
      check({tag, "_start0"}, bus.layer_start, 1);
      if (v.drop_run) bus.run = 1'b0;
      while (!bus.done && t < Budget) begin
         @(negedge clk);
         t++;
      end
      e = sb_q.pop_front();
      if (!bus.done) begin
         check({tag, "_done_seen"}, 0, 1);
      end else begin
         check({tag, "_latency"}, t, e.lat);
         check({tag, "_class_id"}, bus.class_id, e.id);
         check({tag, "_class_score"}, bus.class_score, e.best);
         check({tag, "_err"}, bus.err, e.err);
         check({tag, "_busy"}, bus.busy, 0);
         check({tag, "_start_idle"}, bus.layer_start, 0);
         check({tag, "_onehot"}, onehot_bad, 0);
         check({tag, "_launches"}, order_q.size() - base, e.nl);
         if (order_q.size() - base == e.nl)
            for (int j = 0; j < e.nl; j++) check({tag, "_order"}, order_q[base + j], j);
      end
      if (!v.drop_run) begin
         repeat (3) @(negedge clk);
         check({tag, "_hold_done"}, bus.done, 1);
         check({tag, "_hold_nostart"}, bus.layer_start, 0);
         bus.run = 1'b0;
      end
      @(negedge clk);
      check({tag, "_done_clear"}, bus.done, 0);
   endtask

   function automatic void model(input vec_t v, output logic [3:0] id, output score_t best);
      id   = 4'd0;
      best = v.sc[0];
      for (int j = 1; j < NC; j++)
         if (v.sc[j] > best) begin
            id   = 4'(j);
            best = v.sc[j];
         end
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      vec_t       rv;
      logic [3:0] rid;
      score_t     rbest;

      for (int j = 0; j < NC; j++) begin
         vecs[0].sc[j] = score_t'(j);
         vecs[1].sc[j] = 10;
         vecs[2].sc[j] = -100;
         vecs[3].sc[j] = 5;
         vecs[4].sc[j] = 32'sh8000_0000;
         vecs[5].sc[j] = score_t'(j * 1000);
      end
      vecs[0].sc[7] = 99;            vecs[0].id = 7; vecs[0].best = 99;
      vecs[1].sc[2] = 50;            vecs[1].sc[5] = 50;
      vecs[1].id = 2;                vecs[1].best = 50;
      vecs[2].sc[4] = -3;            vecs[2].id = 4; vecs[2].best = -3;
      vecs[3].id = 0;                vecs[3].best = 5;
      vecs[4].sc[9] = 32'sh8000_0001;
      vecs[4].id = 9;                vecs[4].best = 32'sh8000_0001;
      vecs[5].sc[0] = 32'sh7fff_ffff;
      vecs[5].id = 0;                vecs[5].best = 32'sh7fff_ffff;
      for (int i = 0; i < 6; i++) vecs[i].drop_run = (i == 1);

      bus.run = 1'b0;
      bus.scores = '{default: 0};
      preset = 1'b1;
      repeat (2) @(negedge clk);
      preset = 1'b0;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_start", bus.layer_start, 0);
      check("rst_class_id", bus.class_id, 0);
      check("rst_class_score", bus.class_score, 0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         run_once(vecs[i], vecs[i].id, vecs[i].best, 1'b0, run_lat(dly), NL,
                  $sformatf("vec%0d", i));

      for (int j = 0; j < NC; j++) rv.sc[j] = score_t'($urandom);
      rv.drop_run = 1'b0;
      model(rv, rid, rbest);
      run_once(rv, rid, rbest, 1'b0, run_lat(dly), NL, "random");

      // Shortest legal layer latency: exercises the guard boundary.
      dly = 2;
      run_once(vecs[2], 4'd4, -3, 1'b0, run_lat(2), NL, "min_delay");
      dly = 5;

      // Stale sticky done held high at launch and cleared only on the second start cycle.
      @(negedge clk);
      preset = 1'b1;
      @(negedge clk);
      preset = 1'b0;
      clr_at = 2;
      run_once(vecs[0], 4'd7, 99, 1'b0, run_lat(dly), NL, "stale");
      clr_at = 1;

`ifdef SEQ_TIMEOUT_EN
      hang[2] = 1'b1;
      run_once(vecs[0], 4'd0, 0, 1'b1, 1 + 2 * (dly + 2) + 1 + TO, 3, "timeout");
      hang[2] = 1'b0;
      run_once(vecs[1], 4'd2, 50, 1'b0, run_lat(dly), NL, "after_timeout");
`endif

      // Reset in WAIT_DONE of layer 1, then a clean run.
      @(negedge clk);
      bus.scores = vecs[0].sc;
      bus.run = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_layer1_start", bus.layer_start, 2);
      check("mid_busy", bus.busy, 1);
      reset_n = 1'b0;
      #1;
      check("arst_start", bus.layer_start, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      check("arst_err", bus.err, 0);
      check("arst_class_id", bus.class_id, 0);
      check("arst_class_score", bus.class_score, 0);
      bus.run = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_once(vecs[4], 4'd9, 32'sh8000_0001, 1'b0, run_lat(dly), NL, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
